dma_tx: RTL and testbench
=========================

Name: dma_tx

Overview:
- Memory-to-device DMA engine. It is the reverse direction of the existing device-to-memory DMA.
- On a CPU command it requests the data bus with BR/BG and reads consecutive 4-word lines from data memory. It hands each line to the external device with a ready/valid handshake, then raises a completion interrupt.
- It sits beside the existing DMA on the shared d_address/d_data bus and uses the same BR/BG arbitration with the cpu.

Parameters:
- WORD_SIZE, 16, width of one memory word and of addresses.
- LINE_WORDS, 4, words per memory line; data bus width is WORD_SIZE*LINE_WORDS.
- MEM_LAT, 1, cycles from READ assertion to valid read data (range 1..7).
- LEN_W, 8, width of the line-count and line-index fields.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- cmd  in  1  one-cycle start pulse from the cpu.
- cmd_addr  in  WORD_SIZE  source base word address, sampled with cmd.
- cmd_len  in  LEN_W  number of lines to transfer, sampled with cmd.
- BR  out  1  bus request to the cpu.
- BG  in  1  bus grant from the cpu.
- READ  out  1  memory read strobe.
- addr  out  WORD_SIZE  memory address; high-Z unless BR&&BG.
- data  in  WORD_SIZE*LINE_WORDS  memory read data.
- edata  out  WORD_SIZE*LINE_WORDS  line presented to the device (registered).
- offset  out  LEN_W  index of the line on edata.
- evalid  out  1  edata/offset valid.
- eready  in  1  device accepts the line.
- interrupt  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted cmd until the interrupt cycle, inclusive.

Behaviour:
- Reset values, applied immediately (asynchronous):
  - BR=0, READ=0, addr=Z, edata=0, offset=0, evalid=0, interrupt=0, busy=0.
  - FSM goes to IDLE; line counter and base address are cleared.
- FSM states: IDLE, REQ, RD, SEND, DONE.
- IDLE:
  - cmd=1 with cmd_len!=0: latch base and len, set line index i=0, go to REQ. BR and busy rise on the same edge.
  - cmd=1 with cmd_len=0: go to DONE with no bus request. Result: interrupt and busy high for exactly one cycle, one edge later.
- REQ: BR=1. On the first edge where BG=1, go to RD.
- RD:
  - READ=1 and addr=base+LINE_WORDS*i (mod 2^WORD_SIZE) for exactly MEM_LAT cycles.
  - On the MEM_LAT-th edge: latch data into edata, set offset=i, set evalid=1, go to SEND.
- BG dropped during RD:
  - READ deasserts and addr goes to Z on the next edge; the partial read is discarded.
  - FSM returns to REQ with BR held at 1 and i unchanged.
  - After regrant, the line is re-read from the start with the latency counter reset.
- SEND:
  - READ=0. evalid stays high; edata and offset stay stable until an edge with eready=1.
  - eready already high on the first SEND cycle: the transfer completes in that cycle.
  - On acceptance with i<len-1: evalid=0, i=i+1, go to RD if BG=1, else REQ.
  - On acceptance with i=len-1: evalid=0, BR=0, go to DONE.
  - The bus is held through SEND. BG loss during SEND has no effect until the next RD.
- DONE: interrupt=1 and busy=1 for one cycle, then IDLE with busy=0.
- cmd while busy=1 is ignored: no latch, no state change.
- Simultaneous cmd and the DONE cycle: the cmd is ignored (busy=1).
- Address arithmetic wraps modulo 2^WORD_SIZE.
- offset counts 0..len-1 and never wraps within one transfer.
- Throughput with MEM_LAT=1, constant BG=1 and eready=1:
  - First READ in the cycle after BG is seen.
  - Each line takes 2 cycles (RD, SEND).
  - interrupt occurs 1 cycle after the last SEND.
- RESET mid-transfer: all outputs return to reset values immediately, BR drops, and no interrupt is generated.

Test Plan:
- cmd_addr=0x0040, cmd_len=3, BG granted 2 cycles after BR, eready=1, MEM_LAT=1 -> addr sequence 0x0040, 0x0044, 0x0048 with READ=1 one cycle each. offset 0,1,2 with the matching memory lines on edata. BR low after the 3rd accept; one interrupt pulse; busy low next cycle.
- Device stall: cmd_len=2, eready held 0 for 5 cycles on line 0 -> evalid, edata and offset stable for 6 cycles with no READ issued. Line 1 is read only after the accept.
- Grant loss: BG dropped during the RD of line 1 (MEM_LAT=3), restored 4 cycles later -> READ=0 and addr=Z while revoked. Line 1 is re-read at base+4 for a full 3 cycles; the delivered data equals memory, not a partial value.
- Wrap: cmd_addr=0xFFFC, cmd_len=2 -> addresses 0xFFFC then 0x0000; offsets 0, 1.
- cmd_len=0 -> BR never asserted; interrupt for one cycle one edge after cmd. A second cmd issued while busy is ignored: no extra transfer or interrupt.
- RESET asserted while in SEND of line 1 of 3 -> BR, evalid and busy go to 0 at once, no interrupt. A subsequent cmd starts cleanly at offset 0.

Source files
------------

// File: rtl/dma_tx_if.sv
// Bundle of the cpu command, memory read bus and device handshake of dma_tx.
interface dma_tx_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LEN_W      = 8
);
  localparam int unsigned DATA_W = WORD_SIZE * LINE_WORDS;

  // cpu command
  logic                 cmd;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  // bus arbitration and memory read
  logic                 BR;
  logic                 BG;
  logic                 READ;
  logic [DATA_W-1:0]    data;
  // device side
  logic [DATA_W-1:0]    edata;
  logic [LEN_W-1:0]     offset;
  logic                 evalid;
  logic                 eready;
  // status
  logic                 interrupt;
  logic                 busy;

  modport master (
    input  cmd, cmd_addr, cmd_len, BG, data, eready,
    output BR, READ, edata, offset, evalid, interrupt, busy
  );

  modport slave (
    output cmd, cmd_addr, cmd_len, BG, data, eready,
    input  BR, READ, edata, offset, evalid, interrupt, busy
  );
endinterface

// File: rtl/dma_tx.sv
// Memory-to-device DMA: reads consecutive lines over the shared bus and
// streams them to a device with a ready/valid handshake.
module dma_tx #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  dma_tx_if.master             bus,
  // shared tri-state address line, kept as a plain net so it can be wired-or'd
  output wire  [WORD_SIZE-1:0] addr
);
  localparam int unsigned DATA_W = WORD_SIZE * LINE_WORDS;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, REQ, RD, SEND, DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     lat_q, lat_d;
  logic                 br_q, br_d;
  logic                 read_q, read_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    edata_q, edata_d;
  logic [LEN_W-1:0]     offset_q, offset_d;
  logic                 evalid_q, evalid_d;
  logic                 irq_q, irq_d;
  logic                 busy_q, busy_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    br_d     = br_q;
    read_d   = 1'b0;
    edata_d  = edata_q;
    offset_d = offset_q;
    evalid_d = evalid_q;
    irq_d    = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd) begin
          busy_d = 1'b1;
          if (bus.cmd_len != '0) begin
            base_d  = bus.cmd_addr;
            len_d   = bus.cmd_len;
            idx_d   = '0;
            br_d    = 1'b1;
            state_d = REQ;
          end else begin
            // empty transfer: completion pulse without touching the bus
            irq_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (bus.BG) begin
          read_d  = 1'b1;
          lat_d   = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (!bus.BG) begin
          // grant revoked: drop the partial read and re-request the bus
          lat_d   = '0;
          state_d = REQ;
        end else if (lat_q == CNT_W'(MEM_LAT - 1)) begin
          edata_d  = bus.data;
          offset_d = idx_q;
          evalid_d = 1'b1;
          state_d  = SEND;
        end else begin
          read_d = 1'b1;
          lat_d  = lat_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (bus.eready) begin
          evalid_d = 1'b0;
          if (idx_q == len_q - LEN_W'(1)) begin
            br_d    = 1'b0;
            irq_d   = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + LEN_W'(1);
            lat_d = '0;
            if (bus.BG) begin
              read_d  = 1'b1;
              state_d = RD;
            end else begin
              state_d = REQ;
            end
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    addr_d = base_d + WORD_SIZE'(LINE_WORDS) * WORD_SIZE'(idx_d);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
      br_q     <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      edata_q  <= '0;
      offset_q <= '0;
      evalid_q <= 1'b0;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      br_q     <= br_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      edata_q  <= edata_d;
      offset_q <= offset_d;
      evalid_q <= evalid_d;
      irq_q    <= irq_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.BR        = br_q;
  assign bus.READ      = read_q;
  assign bus.edata     = edata_q;
  assign bus.offset    = offset_q;
  assign bus.evalid    = evalid_q;
  assign bus.interrupt = irq_q;
  assign bus.busy      = busy_q;

  // Drive the address bus only while we own it
  assign addr = (br_q && bus.BG) ? addr_q : {WORD_SIZE{1'bz}};
endmodule

// File: tb/tb_dma_tx.sv
// Self-checking bench for dma_tx: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, selected per test; scoreboard of expected lines checked on accept.
module tb_dma_tx;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD1_BAD2_BAD3;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        cmd_s;
  logic [15:0] cmd_addr_s;
  logic [7:0]  cmd_len_s;
  logic        bg;
  logic        eready_s;
  wire  [15:0] addr1;
  wire  [15:0] addr3;
  int          c3;

  int nchk;
  int nerr;
  int irq_seen;
  int exp_irq;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  off;
    logic [63:0] d;
  } exp_t;
  exp_t exq[$];

  dma_tx_if #(.WORD_SIZE(16), .LINE_WORDS(4), .LEN_W(8)) if1 ();
  dma_tx_if #(.WORD_SIZE(16), .LINE_WORDS(4), .LEN_W(8)) if3 ();

  dma_tx #(.WORD_SIZE(16), .LINE_WORDS(4), .MEM_LAT(1), .LEN_W(8)) u_dma1 (
    .CLK(clk), .RESET(rst), .bus(if1), .addr(addr1));
  dma_tx #(.WORD_SIZE(16), .LINE_WORDS(4), .MEM_LAT(3), .LEN_W(8)) u_dma3 (
    .CLK(clk), .RESET(rst), .bus(if3), .addr(addr3));

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    return {a ^ 16'hC3C3, a + 16'h0101, ~a, a};
  endfunction

  assign if1.cmd      = cmd_s & ~sel;
  assign if3.cmd      = cmd_s & sel;
  assign if1.cmd_addr = cmd_addr_s;
  assign if3.cmd_addr = cmd_addr_s;
  assign if1.cmd_len  = cmd_len_s;
  assign if3.cmd_len  = cmd_len_s;
  assign if1.BG       = bg;
  assign if3.BG       = bg;
  assign if1.eready   = eready_s;
  assign if3.eready   = eready_s;

  // Memory model: data is only valid once READ has been held for MEM_LAT cycles
  assign if1.data = if1.READ ? mem_line(addr1) : JUNK;
  assign if3.data = (if3.READ && c3 >= 2) ? mem_line(addr3) : JUNK;
  always @(posedge clk or posedge rst) begin
    if (rst) c3 <= 0;
    else if (if3.READ && if3.BR && bg) c3 <= c3 + 1;
    else c3 <= 0;
  end

  wire        br        = sel ? if3.BR        : if1.BR;
  wire        read      = sel ? if3.READ      : if1.READ;
  wire [15:0] addr      = sel ? addr3         : addr1;
  wire [63:0] edata     = sel ? if3.edata     : if1.edata;
  wire [7:0]  offset    = sel ? if3.offset    : if1.offset;
  wire        evalid    = sel ? if3.evalid    : if1.evalid;
  wire        interrupt = sel ? if3.interrupt : if1.interrupt;
  wire        busy      = sel ? if3.busy      : if1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_t e;
      e.a   = a + 16'(4 * i);
      e.off = 8'(i);
      e.d   = mem_line(e.a);
      exq.push_back(e);
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic        pv_valid, pv_acc;
  logic [63:0] pv_edata;
  logic [7:0]  pv_off;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv_valid = 1'b0;
      pv_acc   = 1'b0;
    end else begin
      if (read && br && bg) begin
        chk("read_expected", 64'(exq.size() != 0), 1);
        if (exq.size() != 0) chk("read_addr", addr, exq[0].a);
      end
      if (evalid) chk("no_read_in_send", read, 0);
      if (pv_valid && !pv_acc) begin
        chk("hold_evalid", evalid, 1);
        chk("hold_edata", edata, pv_edata);
        chk("hold_offset", offset, pv_off);
      end
      if (evalid && eready_s) begin
        chk("accept_expected", 64'(exq.size() != 0), 1);
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk("offset", offset, e.off);
          chk("edata", edata, e.d);
        end
      end
      if (interrupt) begin
        irq_seen++;
        chk("irq_busy", busy, 1);
      end
      pv_valid = evalid;
      pv_acc   = evalid && eready_s;
      pv_edata = edata;
      pv_off   = offset;
    end
  end

  task automatic issue_cmd(input logic [15:0] a, input logic [7:0] n);
    cmd_s = 1'b1; cmd_addr_s = a; cmd_len_s = n;
    tick();
    cmd_s = 1'b0;
  endtask

  // Complete transfer with grant delay and optional device stall on one line
  task automatic run_xfer(input logic [15:0] a, input logic [7:0] n, input int gdly,
                          input int soff, input int sn, input int exp_cyc);
    int t;
    int st;
    push_exp(a, n);
    exp_irq++;
    eready_s = 1'b1;
    issue_cmd(a, n);
    chk("br_rise", br, 1);
    chk("busy_rise", busy, 1);
    repeat (gdly) begin
      chk("no_read_before_grant", read, 0);
      tick();
    end
    bg = 1'b1;
    t = 0; st = 0;
    while (!interrupt && t < 300) begin
      eready_s = !(evalid && int'(offset) == soff && st < sn);
      if (evalid && !eready_s) st++;
      tick();
      t++;
    end
    eready_s = 1'b1;
    chk("irq_pulse", interrupt, 1);
    chk("xfer_cycles", 64'(t), 64'(exp_cyc));
    chk("br_low_at_irq", br, 0);
    tick();
    chk("irq_one_cycle", interrupt, 0);
    chk("busy_fall", busy, 0);
    chk("sb_drained", 64'(exq.size()), 0);
    bg = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  n;
    int          gdly;
    int          soff;
    int          sn;
    logic        sel;
    int          exp_cyc;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int n;
    nchk = 0; nerr = 0; irq_seen = 0; exp_irq = 0;
    tbl[0] = '{16'h0040, 8'd3, 2, -1, 0, 1'b0, 7};
    tbl[1] = '{16'h0100, 8'd2, 0,  0, 5, 1'b0, 10};
    tbl[2] = '{16'hFFFC, 8'd2, 1, -1, 0, 1'b0, 5};
    tbl[3] = '{16'h1230, 8'd4, 1,  2, 2, 1'b1, 19};
    tbl[4] = '{16'h0008, 8'd1, 0, -1, 0, 1'b1, 5};

    rst = 1'b1; sel = 1'b0; cmd_s = 1'b0; cmd_addr_s = '0; cmd_len_s = '0;
    bg = 1'b0; eready_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_br", if1.BR, 0);
    chk("rst_read", if1.READ, 0);
    chk("rst_evalid", if1.evalid, 0);
    chk("rst_edata", if1.edata, 0);
    chk("rst_offset", if1.offset, 0);
    chk("rst_irq", if1.interrupt, 0);
    chk("rst_busy", if3.busy, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].sel;
      run_xfer(tbl[i].a, tbl[i].n, tbl[i].gdly, tbl[i].soff, tbl[i].sn, tbl[i].exp_cyc);
      tick();
    end

    // Grant revoked during the read of line 1, then restored
    sel = 1'b1;
    push_exp(16'h0200, 8'd2);
    exp_irq++;
    issue_cmd(16'h0200, 8'd2);
    bg = 1'b1;
    n = 0;
    while (!(read && addr == 16'h0204) && n < 50) begin tick(); n++; end
    chk("gl_reached_line1", 64'(read && addr == 16'h0204), 1);
    bg = 1'b0;
    repeat (4) begin
      tick();
      chk("gl_read_off", read, 0);
      chk("gl_br_held", br, 1);
    end
    bg = 1'b1;
    tick();
    n = 0;
    while (read && n < 10) begin n++; tick(); end
    chk("gl_reread_len", 64'(n), 3);
    n = 0;
    while (!interrupt && n < 50) begin tick(); n++; end
    chk("gl_irq", interrupt, 1);
    tick();
    chk("gl_busy_fall", busy, 0);
    bg = 1'b0;
    tick();

    // Zero-length command, with a second command landing in the DONE cycle
    sel = 1'b0;
    exp_irq++;
    cmd_s = 1'b1; cmd_addr_s = 16'h0500; cmd_len_s = 8'd0;
    tick();
    cmd_len_s = 8'd3;
    chk("z_irq", interrupt, 1);
    chk("z_busy", busy, 1);
    chk("z_no_br", br, 0);
    tick();
    cmd_s = 1'b0;
    chk("z_irq_end", interrupt, 0);
    chk("z_busy_end", busy, 0);
    repeat (5) begin
      chk("z_ignored_br", br, 0);
      chk("z_ignored_irq", interrupt, 0);
      tick();
    end

    // Reset while line 1 of 3 sits in SEND
    push_exp(16'h0300, 8'd3);
    issue_cmd(16'h0300, 8'd3);
    bg = 1'b1;
    n = 0;
    while (!(evalid && offset == 8'd1) && n < 50) begin
      eready_s = !(evalid && offset == 8'd1);
      tick();
      n++;
    end
    eready_s = 1'b0;
    chk("r_in_send1", 64'(evalid && offset == 8'd1), 1);
    rst = 1'b1;
    exq.delete();
    #1;
    chk("r_br", br, 0);
    chk("r_evalid", evalid, 0);
    chk("r_busy", busy, 0);
    chk("r_read", read, 0);
    bg = 1'b0;
    eready_s = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("r_no_irq", interrupt, 0);
    end
    run_xfer(16'h0400, 8'd2, 1, -1, 0, 5);
    tick();

    chk("irq_total", 64'(irq_seen), 64'(exp_irq));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
